// File: rtl/burst_mem_pkg.sv
// Shared types and widths for the 4-beat, 64-bit burst memory responder.
package burst_mem_pkg;
    localparam int BURST_W    = 64;
    localparam int LINE_W     = 256;
    localparam int BEATS      = 4;
    localparam int BEAT_IDX_W = 2;

    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
    typedef logic [BURST_W-1:0] beat_t;
endpackage

// File: rtl/burst_mem_responder_if.sv
// Initiator <-> responder burst bus; signal names are seen from the responder side.
interface burst_mem_responder_if;
    import burst_mem_pkg::*;

    logic [31:0] address_i;
    logic        read_i;
    logic        write_i;
    beat_t       burst_i;
    beat_t       burst_o;
    logic        resp_o;
    logic        busy_o;
    logic        err_o;

    modport master (output address_i, read_i, write_i, burst_i,
                    input  burst_o, resp_o, busy_o, err_o);
    modport slave  (input  address_i, read_i, write_i, burst_i,
                    output burst_o, resp_o, busy_o, err_o);
endinterface

// File: rtl/burst_mem_store.sv
// Beat-granular line store: combinational read, synchronous write, synchronous clear.
module burst_mem_store
    import burst_mem_pkg::*;
#(
    parameter int DEPTH_LINES = 16,
    parameter int ADDR_W      = $clog2(DEPTH_LINES) + BEAT_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr_i,
    output beat_t             rdata_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  beat_t             wdata_i
);
    localparam int ENTRIES = DEPTH_LINES * BEATS;

    beat_t mem_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder: accepts line-aligned bursts, waits LATENCY cycles,
// then moves 4 beats to/from the internal line store.
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int LATENCY     = 2,
    parameter int DEPTH_LINES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    burst_mem_responder_if.slave bus
);
    localparam int LINE_IDX_W = $clog2(DEPTH_LINES);

    state_t                  state_q, state_d;
    logic [3:0]              lat_q, lat_d;
    logic [BEAT_IDX_W-1:0]   beat_q, beat_d;
    logic [LINE_IDX_W-1:0]   line_q, line_d;
    logic                    wr_q, wr_d;
    logic                    err_q, err_d;
    logic                    abort, resp, we;
    beat_t                   rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    // A latched write is also abandoned if read rises, since read would have won.
    always_comb begin
        abort   = wr_q ? (!bus.write_i || bus.read_i) : !bus.read_i;
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        line_d  = line_q;
        wr_d    = wr_q;
        err_d   = err_q;
        resp    = 1'b0;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.read_i || bus.write_i) begin
                    wr_d   = !bus.read_i;
                    line_d = bus.address_i[5 +: LINE_IDX_W];
                    beat_d = '0;
                    err_d  = err_q || (bus.read_i && bus.write_i);
                    if (LATENCY == 0) begin
                        state_d = XFER;
                    end else begin
                        state_d = WAIT;
                        lat_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (lat_q == '0) begin
                    state_d = XFER;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            XFER: begin
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    resp   = 1'b1;
                    we     = wr_q;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_IDX_W'(BEATS - 1)) state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    burst_mem_store #(.DEPTH_LINES(DEPTH_LINES)) u_store (
        .clk     (clk),
        .rst     (rst),
        .raddr_i ({line_q, beat_q}),
        .rdata_o (rdata),
        .we_i    (we),
        .waddr_i ({line_q, beat_q}),
        .wdata_i (bus.burst_i)
    );

    assign bus.resp_o  = resp;
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.err_o   = err_q;
    assign bus.burst_o = (resp && !wr_q) ? rdata : '0;
endmodule
